// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serial frame transmitter (zero sync, ones flag, LSB-first
// zero-stuffed data, zero tail) feeding a run-of-ones detector.
// Ports:
//   CLOCK        rising-edge clock
//   RESET        asynchronous active-high reset
//   START        send request, sampled only in IDLE
//   DATA         payload, latched when START is accepted
//   X            registered serial line
//   BUSY         high while a frame is in progress
//   DONE         one-cycle pulse in the first IDLE cycle after TAIL
//   CurrentState FSM state for debug
module serial_frame_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int HEADER_ONES = 3
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] DATA,
    output logic                  X,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [2:0]            CurrentState
);
    localparam int MAXC = DATA_WIDTH > HEADER_ONES ? DATA_WIDTH : HEADER_ONES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        SYNC  = 3'b001,
        FLAG  = 3'b010,
        DATAS = 3'b011,
        STUFF = 3'b100,
        TAIL  = 3'b101
    } state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n, run, run_n;
    logic [DATA_WIDTH-1:0] sr, sr_n;
    logic                  x_n, done_n;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            run   <= '0;
            sr    <= '0;
            X     <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            run   <= run_n;
            sr    <= sr_n;
            X     <= x_n;
            DONE  <= done_n;
        end
    end

    // cnt counts flag cycles in FLAG and data bits in DATA; run tracks the
    // current run of data ones so a flag-length run can never appear in data.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        run_n   = run;
        sr_n    = sr;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    sr_n    = DATA;
                    cnt_n   = '0;
                    run_n   = '0;
                    state_n = SYNC;
                end
            end
            SYNC: begin
                cnt_n   = '0;
                state_n = FLAG;
            end
            FLAG: begin
                cnt_n   = (cnt == CW'(HEADER_ONES - 1)) ? '0 : cnt + CW'(1);
                state_n = (cnt == CW'(HEADER_ONES - 1)) ? DATAS : FLAG;
            end
            DATAS: begin
                cnt_n   = cnt + CW'(1);
                sr_n    = sr >> 1;
                run_n   = sr[0] ? run + CW'(1) : '0;
                state_n = (cnt == CW'(DATA_WIDTH - 1))       ? TAIL  :
                          (run_n == CW'(HEADER_ONES - 1))    ? STUFF : DATAS;
            end
            STUFF: begin
                run_n   = '0;
                state_n = DATAS;
            end
            TAIL: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // X is registered from the next state so it tracks the state register exactly
        x_n = (state_n == FLAG) || ((state_n == DATAS) && sr_n[0]);
    end

    assign BUSY         = (state != IDLE);
    assign CurrentState = state;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed self-checking bench for serial_frame_tx.
module tb_serial_frame_tx;
    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [7:0] DATA  = 8'h00;
    logic       X, BUSY, DONE;
    logic [2:0] CurrentState;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         d0;

    serial_frame_tx #(.DATA_WIDTH(8), .HEADER_ONES(3)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .START(START),
        .DATA(DATA),
        .X(X),
        .BUSY(BUSY),
        .DONE(DONE),
        .CurrentState(CurrentState)
    );

    always #5 CLOCK = ~CLOCK;

    always @(negedge CLOCK) if (DONE) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d);
        START = 1'b1;
        DATA  = d;
        @(posedge CLOCK);
    endtask

    // exp holds the expected X sequence with the first cycle in bit n-1.
    // poke >= 0 raises START with altered DATA during that frame cycle.
    task automatic check_frame(input string tag, input int n, input logic [31:0] exp, input int poke);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK);
            START = 1'b0;
            check($sformatf("%s_x%0d", tag, i), 32'(X), 32'(exp[n-1-i]));
            check($sformatf("%s_busy%0d", tag, i), 32'(BUSY), 32'd1);
            if (i == 0) check($sformatf("%s_sync", tag), 32'(CurrentState), 32'd1);
            if (i == poke) begin
                START = 1'b1;
                DATA  = ~DATA;
            end
        end
        @(negedge CLOCK);
        START = 1'b0;
        check({tag, "_done"}, 32'(DONE), 32'd1);
        check({tag, "_idle"}, 32'(BUSY), 32'd0);
        check({tag, "_xidle"}, 32'(X), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge CLOCK);
        check("rst_x", 32'(X), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_state", 32'(CurrentState), 32'd0);
        RESET = 1'b0;
        @(negedge CLOCK);
        check("idle_busy", 32'(BUSY), 32'd0);

        d0 = done_cnt;
        start_frame(8'h00);
        check_frame("f00", 13, 32'(13'b0111000000000), -1);
        @(negedge CLOCK);
        check("f00_done_low", 32'(DONE), 32'd0);
        check("f00_done_once", done_cnt - d0, 1);

        start_frame(8'hFF);
        check_frame("fff", 16, 32'(16'b0111110110110110), -1);
        @(negedge CLOCK);

        start_frame(8'hA5);
        check_frame("fa5", 13, 32'(13'b0111101001010), -1);
        start_frame(8'h03);
        check_frame("f03", 14, 32'(14'b01111100000000), -1);
        @(negedge CLOCK);

        d0 = done_cnt;
        start_frame(8'hA5);
        check_frame("fpoke", 13, 32'(13'b0111101001010), 6);
        repeat (3) begin
            @(negedge CLOCK);
            check("poke_no_second", 32'(BUSY), 32'd0);
        end
        check("poke_done_once", done_cnt - d0, 1);

        d0 = done_cnt;
        start_frame(8'hFF);
        @(negedge CLOCK);
        START = 1'b0;
        repeat (7) @(negedge CLOCK);
        check("mid_bit2", 32'(X), 32'd1);
        check("mid_state", 32'(CurrentState), 32'd3);
        #2 RESET = 1'b1;
        #1;
        check("arst_x", 32'(X), 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        check("arst_done", 32'(DONE), 32'd0);
        check("arst_state", 32'(CurrentState), 32'd0);
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        repeat (3) @(negedge CLOCK);
        check("arst_no_done", done_cnt - d0, 0);
        check("arst_idle", 32'(BUSY), 32'd0);
        start_frame(8'h00);
        check_frame("after_rst", 13, 32'(13'b0111000000000), -1);
        @(negedge CLOCK);
        check("after_rst_done_low", 32'(DONE), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that produces the bit stream consumed by the team's Moore run-of-ones detectors. It accepts a parallel word and emits a frame on the single-bit line X: a zero sync bit, a flag of consecutive ones, the data LSB-first with zero-bit stuffing, and a zero tail. Stuffing guarantees that a run of HEADER_ONES ones occurs only in the flag, so a downstream detector asserts only on frame start. The block sits on the driving side of the detector's X input.

## Interface
- DATA_WIDTH, 8, payload width in bits (≥2)
- HEADER_ONES, 3, number of consecutive ones in the flag (≥2); data runs are limited to HEADER_ONES-1
- CLOCK  input  1  system clock, rising-edge active
- RESET  input  1  asynchronous, active-high reset
- START  input  1  request to send; sampled only in IDLE
- DATA  input  DATA_WIDTH  payload, latched on the edge that accepts START
- X  output  1  serial line, registered
- BUSY  output  1  high while a frame is in progress
- DONE  output  1  one-cycle pulse after the last frame bit
- CurrentState  output  3  current FSM state, for debug

## Operation
- States and encodings: IDLE=000, SYNC=001, FLAG=010, DATA=011, STUFF=100, TAIL=101. Codes 110/111 go to IDLE on the next edge.
- X is a Moore output, a function of the state: IDLE 0, SYNC 0, FLAG 1, DATA = current shift-register bit, STUFF 0, TAIL 0.
- BUSY=1 in every state except IDLE.
- IDLE: if START=1, latch DATA into the shift register, clear the bit counter and ones-run counter, then go to SYNC. Otherwise stay in IDLE.
- SYNC: lasts 1 cycle, then FLAG.
- FLAG: lasts HEADER_ONES cycles (counter-driven), then DATA.
- DATA: each cycle emits one bit, LSB first, and advances the bit counter. The ones-run counter increments on a 1 and clears on a 0. After each bit, the next state is:
  - TAIL if this was bit DATA_WIDTH-1.
  - Otherwise STUFF if the run has reached HEADER_ONES-1.
  - Otherwise DATA.
- STUFF: lasts 1 cycle, clears the ones-run counter, and returns to DATA without advancing the bit counter.
- No stuff bit is inserted after the final data bit; the TAIL zero terminates the run.
- TAIL: lasts 1 cycle, then IDLE. DONE is set on that same edge.
- DONE is high for exactly the first IDLE cycle after TAIL and is low otherwise.
- START while BUSY=1 is ignored and not queued. DATA changes while BUSY=1 have no effect.
- Frame length in cycles = 1 + HEADER_ONES + DATA_WIDTH + S + 1, where S is the stuff count. S ≤ floor((DATA_WIDTH-1)/(HEADER_ONES-1)).
- Counters are sized for the largest of HEADER_ONES and DATA_WIDTH and saturate in no state.

## Timing
- RESET=1 asynchronously forces IDLE: X=0, BUSY=0, DONE=0, CurrentState=000, and all counters and the shift register cleared. This applies mid-frame too; the partial frame is abandoned with no DONE. The block leaves reset on the first rising edge after RESET falls.
- START is accepted at edge k in IDLE. Then:
  - SYNC, X=0 and BUSY=1, is visible after edge k.
  - The first flag 1 appears after edge k+1.
  - The first data bit appears after edge k+1+HEADER_ONES.
- Back-to-back: START=1 during the DONE cycle is accepted, and SYNC follows directly. The minimum gap between frames is one IDLE cycle.
- All outputs change only on rising CLOCK edges or on RESET assertion.

## Test plan
- Reset: assert RESET asynchronously mid-cycle. X=0, BUSY=0, DONE=0 and CurrentState=000 must appear immediately, before the next edge.
- DATA=8'h00, START pulse: X=0,1,1,1,0,0,0,0,0,0,0,0,0 over 13 cycles. BUSY is high for those 13 cycles, then DONE is high for 1 cycle.
- DATA=8'hFF: X=0,1,1,1 | 1,1,0,1,1,0,1,1,0,1,1 | 0, which is 16 cycles with 3 stuffs and none after the last bit. A reference detector asserts only at the flag.
- DATA=8'hA5: data bits 1,0,1,0,0,1,0,1 with no stuffing, 13 cycles. Then START=1 during the DONE cycle with DATA=8'h03 gives 0,1,1,1,1,1,0,0,0,0,0,0,0,0, which is 14 cycles with 1 stuff.
- START pulsed during the DATA state of a frame, with DATA changed: the current frame is unchanged, no second frame is sent, and DONE pulses exactly once.
- RESET asserted at the 3rd data bit of an 8'hFF frame: outputs go to IDLE values at once and no DONE pulses. A following START with 8'h00 yields the exact 13-cycle frame.
